// File: rtl/compressor_4_2_tree_pipe.sv
// Pipelined 4:2 compressor tree reducing N_OPS (4, 8 or 16) unsigned WIDTH-bit operands to a
// redundant (sum_o, carry_o) pair; one register stage per layer, valid/ready with bubble collapsing.
module compressor_4_2_tree_pipe #(
    parameter int WIDTH = 16,
    parameter int N_OPS = 8
) (
    input  logic                           sys_clk,
    input  logic                           sys_rst_n,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [N_OPS*WIDTH-1:0]         in_ops,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [WIDTH+$clog2(N_OPS)-1:0] sum_o,
    output logic [WIDTH+$clog2(N_OPS)-1:0] carry_o
);
    localparam int LOG_N  = $clog2(N_OPS);
    localparam int LAYERS = LOG_N - 1;
    localparam int OUT_W  = WIDTH + LOG_N;

    typedef logic [OUT_W-1:0] vec_t;

    // One row of 4:2 cells; returns {d, c<<1}. The co of bit i is the ci of bit i+1, so the
    // whole row is a shifted vector; the top co and top c fall off (modulo 2^OUT_W).
    function automatic logic [2*OUT_W-1:0] row_4_2(input vec_t i0, input vec_t i1,
                                                   input vec_t i2, input vec_t i3);
        vec_t s1, co, ci, d, c;
        s1 = i0 ^ i1 ^ i2;
        co = (i0 & i1) | (i0 & i2) | (i1 & i2);
        ci = co << 1;
        d  = s1 ^ i3 ^ ci;
        c  = (s1 & i3) | (s1 & ci) | (i3 & ci);
        return {d, c << 1};
    endfunction

    logic [LAYERS-1:0] v_q, v_d, rdy, up_v, load;

    // A stage is ready when it is empty or everything downstream of it can move.
    always_comb begin
        logic r;
        rdy = '0;
        // NOTE: blocking '=' is correct here: r is a running combinational value, not state.
        r = out_ready;
        for (int k = LAYERS - 1; k >= 0; k--) begin
            r      = !v_q[k] || r;
            rdy[k] = r;
        end
    end

    always_comb begin
        up_v = LAYERS'({v_q, in_valid});
        load = up_v & rdy;
        v_d  = (up_v & rdy) | (v_q & ~rdy);
    end

    // NOTE: state registers use non-blocking '<=' so every flop samples pre-edge values.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) v_q <= '0;
        else            v_q <= v_d;
    end

    assign in_ready  = rdy[0];
    assign out_valid = v_q[LAYERS-1];

    for (genvar j = 0; j < LAYERS; j++) begin : g_layer
        localparam int N_IN  = N_OPS >> j;
        localparam int N_OUT = N_IN / 2;

        vec_t in_vec [N_IN];
        vec_t data_d [N_OUT];
        vec_t data_q [N_OUT];

        if (j == 0) begin : g_src
            always_comb begin
                for (int k = 0; k < N_IN; k++) in_vec[k] = vec_t'(in_ops[k*WIDTH +: WIDTH]);
            end
        end else begin : g_src
            always_comb begin
                for (int k = 0; k < N_IN; k++) in_vec[k] = g_layer[j-1].data_q[k];
            end
        end

        // Vectors 4m..4m+3 feed cell row m, which produces vectors 2m (d) and 2m+1 (carry).
        always_comb begin
            for (int m = 0; m < N_OUT / 2; m++) begin
                {data_d[2*m], data_d[2*m+1]} = row_4_2(in_vec[4*m], in_vec[4*m+1],
                                                       in_vec[4*m+2], in_vec[4*m+3]);
            end
        end

        // NOTE: the data registers are reset too, so sum_o/carry_o read as zero out of reset.
        always_ff @(posedge sys_clk or negedge sys_rst_n) begin
            if (!sys_rst_n) begin
                for (int m = 0; m < N_OUT; m++) data_q[m] <= '0;
            end else if (load[j]) begin
                for (int m = 0; m < N_OUT; m++) data_q[m] <= data_d[m];
            end
        end
    end

    assign sum_o   = g_layer[LAYERS-1].data_q[0];
    assign carry_o = g_layer[LAYERS-1].data_q[1];

endmodule

// File: tb/tb_compressor_4_2_tree_pipe.sv
// Scoreboard bench: an 8x16 instance for streaming/back-pressure/reset and a 4x1 instance
// exercising every single-bit 4:2 cell input combination.
`timescale 1ns/1ps
module tb_compressor_4_2_tree_pipe;
    localparam int WIDTH = 16;
    localparam int N_OPS = 8;
    localparam int OUT_W = 19;

    logic sys_clk = 1'b0;
    logic sys_rst_n = 1'b0;
    always #5 sys_clk = ~sys_clk;

    logic                   in_valid, in_ready, out_valid, out_ready;
    logic [N_OPS*WIDTH-1:0] in_ops;
    logic [OUT_W-1:0]       sum_o, carry_o;

    logic       s_in_valid, s_in_ready, s_out_valid, s_out_ready;
    logic [3:0] s_in_ops;
    logic [2:0] s_sum, s_carry;

    compressor_4_2_tree_pipe #(.WIDTH(WIDTH), .N_OPS(N_OPS)) u_dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_ops(in_ops),
        .out_valid(out_valid), .out_ready(out_ready), .sum_o(sum_o), .carry_o(carry_o)
    );

    compressor_4_2_tree_pipe #(.WIDTH(1), .N_OPS(4)) u_cell (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
        .in_valid(s_in_valid), .in_ready(s_in_ready), .in_ops(s_in_ops),
        .out_valid(s_out_valid), .out_ready(s_out_ready), .sum_o(s_sum), .carry_o(s_carry)
    );

    typedef struct {
        logic [2:0] total;
        bit         exact;
        logic [2:0] sum;
        logic [2:0] carry;
    } cell_exp_t;

    int               n_vec = 0;
    int               n_err = 0;
    logic [OUT_W-1:0] exp_q [$];
    cell_exp_t        cell_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [OUT_W-1:0] model(input logic [N_OPS*WIDTH-1:0] ops);
        logic [OUT_W-1:0] acc;
        acc = '0;
        for (int k = 0; k < N_OPS; k++) acc += OUT_W'(ops[k*WIDTH +: WIDTH]);
        return acc;
    endfunction

    // Monitors: pop and compare whenever a result is handed downstream.
    logic [OUT_W-1:0] mon_tot;
    always @(negedge sys_clk) begin
        if (sys_rst_n && out_valid && out_ready) begin
            mon_tot = sum_o + carry_o;
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_out: got %0h, expected no output (t=%0t)", mon_tot, $time);
            end else begin
                check("result", 32'(mon_tot), 32'(exp_q.pop_front()));
            end
        end
    end

    logic [2:0] cell_tot;
    cell_exp_t  cell_e;
    always @(negedge sys_clk) begin
        if (sys_rst_n && s_out_valid && s_out_ready) begin
            cell_tot = s_sum + s_carry;
            if (cell_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL cell_unexpected_out: got %0h, expected no output", cell_tot);
            end else begin
                cell_e = cell_q.pop_front();
                check("cell_total", 32'(cell_tot), 32'(cell_e.total));
                if (cell_e.exact) begin
                    check("cell_sum", 32'(s_sum), 32'(cell_e.sum));
                    check("cell_carry", 32'(s_carry), 32'(cell_e.carry));
                end
            end
        end
    end

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic drain(input string name);
        int budget;
        budget = 50;
        out_ready = 1'b1;
        in_valid  = 1'b0;
        while ((exp_q.size() != 0 || cell_q.size() != 0) && budget > 0) begin
            tick();
            budget--;
        end
        check({name, "_drain"}, 32'(exp_q.size() + cell_q.size()), 32'd0);
        repeat (3) tick();
    endtask

    // Push one directed set, holding in_valid until accepted.
    task automatic send(input string name, input logic [N_OPS*WIDTH-1:0] ops,
                        input logic [OUT_W-1:0] exp);
        int budget;
        bit done;
        budget = 100;
        done = 1'b0;
        in_valid = 1'b1;
        in_ops = ops;
        while (!done && budget > 0) begin
            @(negedge sys_clk);
            if (in_ready) begin
                exp_q.push_back(exp);
                done = 1'b1;
            end
            tick();
            budget--;
        end
        check({name, "_accepted"}, 32'(done), 32'd1);
        in_valid = 1'b0;
    endtask

    logic [N_OPS*WIDTH-1:0] set_a, set_b, set_c, set_z;
    logic [OUT_W-1:0]       bp_tot;
    int                     sent;
    bit                     acc;

    initial begin
        in_valid = 1'b0; in_ops = '0; out_ready = 1'b0;
        s_in_valid = 1'b0; s_in_ops = '0; s_out_ready = 1'b1;

        // Reset held with random inputs.
        for (int c = 0; c < 4; c++) begin
            in_valid   = 1'($urandom_range(0, 1));
            in_ops     = {4{$urandom()}};
            out_ready  = 1'($urandom_range(0, 1));
            s_in_valid = 1'($urandom_range(0, 1));
            s_in_ops   = 4'($urandom_range(0, 15));
            @(negedge sys_clk);
            check("rst_out_valid", 32'(out_valid), 32'd0);
            check("rst_sum", 32'(sum_o), 32'd0);
            check("rst_carry", 32'(carry_o), 32'd0);
            tick();
        end
        in_valid = 1'b0; s_in_valid = 1'b0; out_ready = 1'b1;
        sys_rst_n = 1'b1;
        @(negedge sys_clk);
        check("post_rst_in_ready", 32'(in_ready), 32'd1);
        check("post_rst_cell_in_ready", 32'(s_in_ready), 32'd1);
        tick();

        // All operands 16'hFFFF: 8*65535 = 0x7FFF8, valid two edges after acceptance.
        in_valid = 1'b1;
        in_ops   = '1;
        @(negedge sys_clk);
        check("ones_in_ready", 32'(in_ready), 32'd1);
        exp_q.push_back(19'h7FFF8);
        tick();
        in_valid = 1'b0;
        @(negedge sys_clk);
        check("ones_valid_edge1", 32'(out_valid), 32'd0);
        @(negedge sys_clk);
        check("ones_valid_edge2", 32'(out_valid), 32'd1);
        tick();
        drain("ones");

        // Every 4:2 cell input combination; three hand-derived exact pairs.
        for (int i = 0; i < 16; i++) begin
            cell_exp_t e;
            e.total = 3'($countones(4'(i)));
            e.exact = 1'b0; e.sum = '0; e.carry = '0;
            if (i == 0)  begin e.exact = 1'b1; e.sum = 3'd0; e.carry = 3'd0; end
            if (i == 5)  begin e.exact = 1'b1; e.sum = 3'd2; e.carry = 3'd0; end
            if (i == 15) begin e.exact = 1'b1; e.sum = 3'd2; e.carry = 3'd2; end
            s_in_valid = 1'b1;
            s_in_ops   = 4'(i);
            @(negedge sys_clk);
            check("cell_in_ready", 32'(s_in_ready), 32'd1);
            cell_q.push_back(e);
            tick();
        end
        s_in_valid = 1'b0;
        drain("cell");

        // Back-pressure: A (1..8 -> 0x24), B (8 x 0x1000 -> 0x8000), C (0xFFFF+1 -> 0x10000).
        set_a = {16'd8, 16'd7, 16'd6, 16'd5, 16'd4, 16'd3, 16'd2, 16'd1};
        set_b = {8{16'h1000}};
        set_c = {16'hFFFF, 96'd0, 16'h0001};
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_ops    = set_a;
        @(negedge sys_clk);
        check("bp_a_in_ready", 32'(in_ready), 32'd1);
        exp_q.push_back(19'h00024);
        tick();
        in_ops = set_b;
        @(negedge sys_clk);
        check("bp_b_in_ready", 32'(in_ready), 32'd1);
        exp_q.push_back(19'h08000);
        tick();
        in_ops = set_c;
        for (int c = 0; c < 3; c++) begin
            @(negedge sys_clk);
            bp_tot = sum_o + carry_o;
            check("bp_full_in_ready", 32'(in_ready), 32'd0);
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_hold_a", 32'(bp_tot), 32'h24);
            tick();
        end
        out_ready = 1'b1;
        @(negedge sys_clk);
        check("bp_release_in_ready", 32'(in_ready), 32'd1);
        exp_q.push_back(19'h10000);
        tick();
        in_valid = 1'b0;
        drain("bp");

        // Random streaming with random in_valid / out_ready.
        sent = 0;
        for (int cyc = 0; cyc < 20000 && sent < 1000; cyc++) begin
            if (!in_valid && $urandom_range(0, 3) != 0) begin
                in_valid = 1'b1;
                in_ops   = {4{$urandom()}};
            end
            out_ready = ($urandom_range(0, 3) != 0);
            @(negedge sys_clk);
            acc = in_valid && in_ready;
            if (acc) begin
                exp_q.push_back(model(in_ops));
                sent++;
            end
            tick();
            if (acc) in_valid = 1'b0;
        end
        check("stream_sent", 32'(sent), 32'd1000);
        drain("stream");

        // Mid-stream reset with two sets in flight; neither may ever appear.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_ops    = {8{16'h00AA}};
        @(negedge sys_clk);
        check("mr_x_in_ready", 32'(in_ready), 32'd1);
        tick();
        in_ops = {8{16'h0055}};
        @(negedge sys_clk);
        check("mr_y_in_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        check("mr_pre_valid", 32'(out_valid), 32'd1);
        sys_rst_n = 1'b0;
        #1;
        check("mr_async_valid", 32'(out_valid), 32'd0);
        tick();
        sys_rst_n = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge sys_clk);
            check("mr_idle_valid", 32'(out_valid), 32'd0);
            tick();
        end
        set_z = {8{16'h0003}};
        send("mr_z", set_z, 19'h00018);
        drain("mr");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish, expected completion within 1ms");
        $fatal(1, "watchdog");
    end

endmodule
